rect_plotter: RTL

RECT_PLOTTER -- requirements
Module: rect_plotter

---
 rtl/vga_draw_pkg.sv | 13 +
 rtl/raster_scan.sv | 39 +++
 rtl/rect_plotter.sv | 110 +++++++++++
 3 files changed

// File: rtl/vga_draw_pkg.sv
// vga_draw_pkg: FSM state encoding and draw-mode constants shared by the VGA drawing blocks.
package vga_draw_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRAW   = 2'd1,
        FINISH = 2'd2
    } state_t;

    localparam logic MODE_FILL    = 1'b0;
    localparam logic MODE_OUTLINE = 1'b1;

endpackage

// File: rtl/raster_scan.sv
// raster_scan: column/row scan counters over a w x h area, advancing left to right, then top to bottom.
module raster_scan #(
    parameter int DIM_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DIM_W-1:0] w,
    input  logic [DIM_W-1:0] h,
    input  logic             advance,
    input  logic             clear,
    output logic [DIM_W-1:0] col,
    output logic [DIM_W-1:0] row,
    output logic             last
);

    logic [DIM_W-1:0] col_q, col_d, row_q, row_d;
    logic             col_end;

    always_comb begin
        col_end = col_q == w - DIM_W'(1);
        last    = col_end && (row_q == h - DIM_W'(1));
        col_d   = clear ? '0 : advance ? (col_end ? '0 : col_q + DIM_W'(1)) : col_q;
        row_d   = clear ? '0 : (advance && col_end) ? row_q + DIM_W'(1) : row_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    assign col = col_q;
    assign row = row_q;

endmodule

// File: rtl/rect_plotter.sv
// rect_plotter: filled/outline rectangle rasteriser driving one VGA pixel per cycle.
// Define RECT_PLOTTER_CLIP_EN to suppress plot for pixels beyond X_MAX/Y_MAX instead of wrapping.
module rect_plotter
    import vga_draw_pkg::*;
#(
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int DIM_W    = 5,
    parameter int COLOUR_W = 3,
    parameter int X_MAX    = 159,
    parameter int Y_MAX    = 119
) (
    input  logic                CLOCK_50,
    input  logic                resetn,
    input  logic                start,
    input  logic [X_W-1:0]      x0,
    input  logic [Y_W-1:0]      y0,
    input  logic [DIM_W-1:0]    w,
    input  logic [DIM_W-1:0]    h,
    input  logic [COLOUR_W-1:0] colour_in,
    input  logic                outline,
    output logic                busy,
    output logic                done,
    output logic [X_W-1:0]      x,
    output logic [Y_W-1:0]      y,
    output logic [COLOUR_W-1:0] colour,
    output logic                plot
);

    state_t                state_q, state_d;
    logic [X_W-1:0]        x0_q;
    logic [Y_W-1:0]        y0_q;
    logic [DIM_W-1:0]      w_q, h_q;
    logic [COLOUR_W-1:0]   colour_q;
    logic                  outline_q;
    logic [DIM_W-1:0]      col, row;
    logic                  last, accept, border, oob;
    logic [X_W:0]          x_ext;
    logic [Y_W:0]          y_ext;

    raster_scan #(.DIM_W(DIM_W)) u_scan (
        .clk     (CLOCK_50),
        .rst_n   (resetn),
        .w       (w_q),
        .h       (h_q),
        .advance (state_q == DRAW),
        .clear   (state_q != DRAW),
        .col     (col),
        .row     (row),
        .last    (last)
    );

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                accept  = start;
                state_d = !start ? IDLE : (w == '0 || h == '0) ? FINISH : DRAW;
            end
            DRAW:    state_d = last ? FINISH : DRAW;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            x0_q      <= '0;
            y0_q      <= '0;
            w_q       <= '0;
            h_q       <= '0;
            colour_q  <= '0;
            outline_q <= MODE_FILL;
        end else begin
            state_q <= state_d;
            if (accept) begin
                x0_q      <= x0;
                y0_q      <= y0;
                w_q       <= w;
                h_q       <= h;
                colour_q  <= colour_in;
                outline_q <= outline;
            end
        end
    end

    // Unwrapped sums tell whether the pixel lies past the visible screen edge
    assign x_ext  = {1'b0, x0_q} + (X_W+1)'(col);
    assign y_ext  = {1'b0, y0_q} + (Y_W+1)'(row);
    assign oob    = (x_ext > (X_W+1)'(X_MAX)) || (y_ext > (Y_W+1)'(Y_MAX));
    assign border = (outline_q == MODE_FILL) || (col == '0) || (row == '0) ||
                    (col == w_q - DIM_W'(1)) || (row == h_q - DIM_W'(1));

    assign x      = x0_q + X_W'(col);
    assign y      = y0_q + Y_W'(row);
    assign colour = colour_q;
    assign busy   = state_q != IDLE;
    assign done   = state_q == FINISH;

`ifdef RECT_PLOTTER_CLIP_EN
    assign plot = (state_q == DRAW) && border && !oob;
`else
    logic unused_oob;
    assign unused_oob = oob;
    assign plot = (state_q == DRAW) && border;
`endif

endmodule
